mac_dot_engine: RTL

Parametrised, pipelined multi-lane dot-product engine. It is the next-generation multiply-accumulate unit in the compute datapath.
- Each accepted beat carries LANES operand pairs. The lane products are summed and accumulated across beats until a beat marked `in_last` arrives.
- The finished vector result is then presented on a valid/ready output port with overflow status and a beat count.
- Supports signed and unsigned operands, optional saturation, synchronous abort, and full backpressure.

---
 rtl/mac_dot_engine.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mac_dot_engine.sv
// Pipelined multi-lane dot-product engine: capture, multiply, lane sum, accumulate.
// Per-beat signedness, optional saturation, synchronous abort and output backpressure.
module mac_dot_engine #(
    parameter int WIDTH    = 32,
    parameter int LANES    = 4,
    parameter int ACC_W    = 80,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_a,
    input  logic [LANES*WIDTH-1:0]   in_b,
    input  logic                     in_signed,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic                     out_overflow,
    output logic [CNT_W-1:0]         out_beats
);

    localparam int PW    = 2 * WIDTH;
    localparam int SUM_W = PW + $clog2(LANES);

    function automatic logic [PW-1:0] mul_lane(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sgn);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = sgn ? PW'($signed(a)) : PW'(a);
        eb = sgn ? PW'($signed(b)) : PW'(b);
        return ea * eb;
    endfunction

    function automatic logic [SUM_W-1:0] ext_prod(input logic [PW-1:0] p, input logic sgn);
        return sgn ? SUM_W'($signed(p)) : SUM_W'(p);
    endfunction

    // Returns {overflow, result}; the signed view keeps one guard bit above the accumulator.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] add,
                                               input logic             sgn);
        logic [ACC_W:0]   s;
        logic             ov;
        logic [ACC_W-1:0] r;
        if (sgn) begin
            s  = {acc[ACC_W-1], acc} + {add[ACC_W-1], add};
            ov = s[ACC_W] ^ s[ACC_W-1];
            r  = s[ACC_W-1:0];
            if (ov && SATURATE != 0)
                r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            s  = {1'b0, acc} + {1'b0, add};
            ov = s[ACC_W];
            r  = s[ACC_W-1:0];
            if (ov && SATURATE != 0)
                r = '1;
        end
        return {ov, r};
    endfunction

    logic stall;
    logic accept;

    logic                   vld_p0_q, sgn_p0_q, last_p0_q;
    logic [LANES*WIDTH-1:0] a_p0_q, b_p0_q;
    logic                   vld_p1_q, sgn_p1_q, last_p1_q;
    logic [LANES*PW-1:0]    prod_p1_q, prod_p1_d;
    logic                   vld_p2_q, sgn_p2_q, last_p2_q;
    logic [SUM_W-1:0]       sum_p2_q, sum_p2_d;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;

    logic [ACC_W:0]   add_res;
    logic [ACC_W-1:0] addend;
    logic [CNT_W-1:0] cnt_inc;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !clear && !stall;
    assign accept   = in_valid && in_ready;

    // S0: input capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0_q  <= 1'b0;
            sgn_p0_q  <= 1'b0;
            last_p0_q <= 1'b0;
            a_p0_q    <= '0;
            b_p0_q    <= '0;
        end else if (clear) begin
            vld_p0_q  <= 1'b0;
        end else if (!stall) begin
            vld_p0_q  <= accept;
            sgn_p0_q  <= in_signed;
            last_p0_q <= in_last;
            a_p0_q    <= in_a;
            b_p0_q    <= in_b;
        end
    end

    // S1: per-lane multiply
    always_comb begin
        prod_p1_d = '0;
        for (int l = 0; l < LANES; l++)
            prod_p1_d[l*PW +: PW] = mul_lane(a_p0_q[l*WIDTH +: WIDTH],
                                             b_p0_q[l*WIDTH +: WIDTH], sgn_p0_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q  <= 1'b0;
            sgn_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            prod_p1_q <= '0;
        end else if (clear) begin
            vld_p1_q  <= 1'b0;
        end else if (!stall) begin
            vld_p1_q  <= vld_p0_q;
            sgn_p1_q  <= sgn_p0_q;
            last_p1_q <= last_p0_q;
            prod_p1_q <= prod_p1_d;
        end
    end

    // S2: lane sum
    always_comb begin
        sum_p2_d = '0;
        for (int l = 0; l < LANES; l++)
            sum_p2_d = sum_p2_d + ext_prod(prod_p1_q[l*PW +: PW], sgn_p1_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2_q  <= 1'b0;
            sgn_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            sum_p2_q  <= '0;
        end else if (clear) begin
            vld_p2_q  <= 1'b0;
        end else if (!stall) begin
            vld_p2_q  <= vld_p1_q;
            sgn_p2_q  <= sgn_p1_q;
            last_p2_q <= last_p1_q;
            sum_p2_q  <= sum_p2_d;
        end
    end

    // S3: accumulate and output register; an aborted beat never reaches the output
    assign addend  = sgn_p2_q ? ACC_W'($signed(sum_p2_q)) : ACC_W'(sum_p2_q);
    assign add_res = sat_add(acc_q, addend, sgn_p2_q);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_beats_d = out_beats_q;
        if (clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (!stall && vld_p2_q) begin
            if (last_p2_q) begin
                out_valid_d = 1'b1;
                out_sum_d   = add_res[ACC_W-1:0];
                out_ovf_d   = ovf_q | add_res[ACC_W];
                out_beats_d = cnt_inc;
                acc_d       = '0;
                ovf_d       = 1'b0;
                cnt_d       = '0;
            end else begin
                acc_d = add_res[ACC_W-1:0];
                ovf_d = ovf_q | add_res[ACC_W];
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_overflow = out_ovf_q;
    assign out_beats    = out_beats_q;

endmodule
